disp14_scan_ctrl: RTL

//  Scan controller for the 12-digit, 14-segment multiplexed display.

---
 rtl/disp14_scan_ctrl.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/disp14_scan_ctrl.sv
// Scan controller for a multiplexed 14-segment display: character buffer, glyph decode, digit scan.
// Optional text rotation is compiled in with `define SCROLL_EN.
module disp14_scan_ctrl #(
  parameter int unsigned NUM_DIGITS    = 12,
  parameter int unsigned DWELL_CYCLES  = 1000,
  parameter int unsigned BLANK_CYCLES  = 2,
  parameter int unsigned SCROLL_FRAMES = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [3:0]            wr_addr,
  input  logic [5:0]            wr_char,
  output logic [NUM_DIGITS-1:0] sel,
  output logic [13:0]           segm,
  output logic                  frame_tick
);

  localparam int unsigned TMAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int unsigned TW   = (TMAX <= 1) ? 1 : $clog2(TMAX);
  localparam int unsigned IW   = (NUM_DIGITS <= 1) ? 1 : $clog2(NUM_DIGITS);
  localparam int unsigned PRE  = (DWELL_CYCLES >= 2) ? DWELL_CYCLES - 2 : 0;

  localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_CYCLES - 1);
  localparam logic [TW-1:0] DWELL_LAST = TW'(DWELL_CYCLES - 1);
  localparam logic [TW-1:0] DWELL_PRE  = TW'(PRE);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [IW:0]   ND_W       = (IW+1)'(NUM_DIGITS);

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [IW-1:0] idx;
  logic [IW-1:0] offset;
  logic [IW-1:0] rd_idx;
  logic [IW:0]   rd_sum;
  logic [5:0]    rd_char;
  logic [5:0]    char_buf [NUM_DIGITS];
  logic          wr_fire;
  logic          last_digit;
  logic          show_end;

  function automatic logic [13:0] glyph(input logic [5:0] code);
    // bit order: a b c d e f g1 g2 h(ul diag) i(up vert) j(ur diag) k(lr diag) l(low vert) m(ll diag)
    case (code)
      6'd1:  glyph = 14'b11101111000000; // A
      6'd2:  glyph = 14'b11110001010010; // B
      6'd3:  glyph = 14'b10011100000000; // C
      6'd4:  glyph = 14'b11110000010010; // D
      6'd5:  glyph = 14'b10011111000000; // E
      6'd6:  glyph = 14'b10001110000000; // F
      6'd7:  glyph = 14'b10111101000000; // G
      6'd8:  glyph = 14'b01101111000000; // H
      6'd9:  glyph = 14'b10010000010010; // I
      6'd10: glyph = 14'b01111000000000; // J
      6'd11: glyph = 14'b00001110001100; // K
      6'd12: glyph = 14'b00011100000000; // L
      6'd13: glyph = 14'b01101100101000; // M
      6'd14: glyph = 14'b01101100100100; // N
      6'd15: glyph = 14'b11111100000000; // O
      6'd16: glyph = 14'b11001111000000; // P
      6'd17: glyph = 14'b11111100000100; // Q
      6'd18: glyph = 14'b11001111000100; // R
      6'd19: glyph = 14'b10110111000000; // S
      6'd20: glyph = 14'b10000000010010; // T
      6'd21: glyph = 14'b01111100000000; // U
      6'd22: glyph = 14'b00001100001001; // V
      6'd23: glyph = 14'b01101100000101; // W
      6'd24: glyph = 14'b00000000101101; // X
      6'd25: glyph = 14'b00000000101010; // Y
      6'd26: glyph = 14'b10010000001001; // Z
      6'd27: glyph = 14'b11101100100100; // N-tilde: N with top bar as tilde
      6'd28: glyph = 14'b11111100001001; // 0
      6'd29: glyph = 14'b01100000001000; // 1
      6'd30: glyph = 14'b11011011000000; // 2
      6'd31: glyph = 14'b11110001000000; // 3
      6'd32: glyph = 14'b01100111000000; // 4
      6'd33: glyph = 14'b10010110000100; // 5
      6'd34: glyph = 14'b10111111000000; // 6
      6'd35: glyph = 14'b11100000000000; // 7
      6'd36: glyph = 14'b11111111000000; // 8
      6'd37: glyph = 14'b11110111000000; // 9
      default: glyph = '0;
    endcase
  endfunction

  assign wr_fire    = wr_valid & wr_ready;
  assign last_digit = (idx == IDX_LAST);
  assign show_end   = (state == SHOW) && (timer == DWELL_LAST);

  always_comb begin
    rd_sum = {1'b0, idx} + {1'b0, offset};
    rd_idx = (rd_sum >= ND_W) ? IW'(rd_sum - ND_W) : IW'(rd_sum);
    // Write-first: a write landing on the same edge as the glyph latch must be the one shown.
    rd_char = (wr_fire && (wr_addr == 4'(rd_idx))) ? wr_char : char_buf[rd_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) char_buf[i] <= '0;
    end else if (wr_fire) begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++)
        if (wr_addr == 4'(i)) char_buf[i] <= wr_char;
    end
  end

`ifdef SCROLL_EN
  localparam int unsigned    FW       = (SCROLL_FRAMES <= 1) ? 1 : $clog2(SCROLL_FRAMES);
  localparam logic [FW-1:0] FRM_LAST = FW'(SCROLL_FRAMES - 1);

  logic [FW-1:0] frm_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      offset  <= '0;
      frm_cnt <= '0;
    end else if (!enable) begin
      offset  <= '0;
      frm_cnt <= '0;
    end else if (show_end && last_digit) begin
      if (frm_cnt == FRM_LAST) begin
        frm_cnt <= '0;
        offset  <= (offset == IDX_LAST) ? '0 : offset + 1'b1;
      end else begin
        frm_cnt <= frm_cnt + 1'b1;
      end
    end
  end
`else
  assign offset = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      timer      <= '0;
      idx        <= '0;
      sel        <= '0;
      segm       <= '0;
      frame_tick <= 1'b0;
      wr_ready   <= 1'b1;
    end else begin
      frame_tick <= 1'b0;
      if (!enable) begin
        state    <= IDLE;
        timer    <= '0;
        idx      <= '0;
        sel      <= '0;
        segm     <= '0;
        wr_ready <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            state    <= BLANK;
            timer    <= '0;
            sel      <= '0;
            segm     <= '0;
            wr_ready <= 1'b1;
          end
          BLANK: begin
            if (timer == BLANK_LAST) begin
              state    <= SHOW;
              timer    <= '0;
              sel      <= NUM_DIGITS'(1) << idx;
              segm     <= glyph(rd_char);
              wr_ready <= 1'b0;
              // Single-cycle dwell: the only SHOW cycle is also the frame's last one.
              if ((DWELL_CYCLES == 1) && last_digit) frame_tick <= 1'b1;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          SHOW: begin
            if (show_end) begin
              state    <= BLANK;
              timer    <= '0;
              sel      <= '0;
              segm     <= '0;
              wr_ready <= 1'b1;
              idx      <= last_digit ? '0 : idx + 1'b1;
            end else begin
              timer <= timer + 1'b1;
              // Registered one cycle early so the pulse coincides with the final SHOW cycle.
              if ((DWELL_CYCLES >= 2) && (timer == DWELL_PRE) && last_digit) frame_tick <= 1'b1;
            end
          end
          default: begin
            state    <= IDLE;
            timer    <= '0;
            idx      <= '0;
            sel      <= '0;
            segm     <= '0;
            wr_ready <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
